// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard control for the 5-stage MIPS pipeline. Each architectural register
// (except $0) has a countdown counter loaded with the producer's latency class
// when it issues. A consumer stalls in D while its source counter says the
// value is not yet forwardable. A writer stalls while an older, slower write to
// the same register is still outstanding. A two-state FSM turns an M-stage
// exception or ERET into a registered fetch redirect.
//
// Optional feature: define HAZARD_PERF_EN to add three 32-bit performance
// counters (freeze cycles, data-stall cycles, exception redirects).
//
// Ports:
//   clk, resetn                  clock, asynchronous active-low reset
//   issue_valid                  D-stage instruction wants to leave D
//   issue_rs/rt, issue_rs/rt_en  source registers and their read enables
//   issue_read_d                 sources consumed in D (branch, JR, JALR)
//   issue_wr_en, issue_wr        destination write enable / register
//   issue_lat                    cycles until the result is forwardable
//   i_stall, d_stall, div_stall  external freeze sources
//   except_type, cp0_epc         M-stage exception code, EPC for ERET
//   stallF..stallW               hold stage registers
//   flushD..flushW               clear stage registers
//   redirect_valid, redirect_pc  fetch redirect request and target
//   perf_*_cnt                   performance counters (HAZARD_PERF_EN only)
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int          NREG      = 32,
    parameter int          LAT_W     = 3,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE = 32'h0000000E
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             issue_valid,
    input  logic [4:0]       issue_rs,
    input  logic [4:0]       issue_rt,
    input  logic             issue_rs_en,
    input  logic             issue_rt_en,
    input  logic             issue_read_d,
    input  logic             issue_wr_en,
    input  logic [4:0]       issue_wr,
    input  logic [LAT_W-1:0] issue_lat,
    input  logic             i_stall,
    input  logic             d_stall,
    input  logic             div_stall,
    input  logic [31:0]      except_type,
    input  logic [31:0]      cp0_epc,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             stallW,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic             redirect_valid,
`ifdef HAZARD_PERF_EN
    output logic [31:0]      perf_freeze_cnt,
    output logic [31:0]      perf_dstall_cnt,
    output logic [31:0]      perf_exc_cnt,
`endif
    output logic [31:0]      redirect_pc
);

    typedef enum logic {ST_RUN, ST_REDIR} state_t;

    state_t            r_state;
    logic [31:0]       r_redirect_pc;
    logic [LAT_W-1:0]  r_cnt      [NREG];
    logic [LAT_W-1:0]  w_cnt_next [NREG];

    logic w_redir;
    logic w_freeze;
    logic w_exc;
    logic w_advance;
    logic w_rs_busy;
    logic w_rt_busy;
    logic w_waw;
    logic w_dstall;
    logic w_accept;

    assign w_redir  = (r_state == ST_REDIR);
    assign w_freeze = i_stall | d_stall | div_stall | w_redir;
    // Exceptions are taken in RUN even while frozen.
    assign w_exc    = (r_state == ST_RUN) && (except_type != 32'd0);
    assign w_advance = (r_state == ST_RUN) && !w_freeze;

    // A D-stage reader needs the value now (count 0); an E-stage reader can
    // take it through the forwarding path one cycle later (count <= 1).
    assign w_rs_busy = issue_rs_en && (issue_rs != 5'd0) &&
                       (r_cnt[issue_rs] > (issue_read_d ? LAT_W'(0) : LAT_W'(1)));
    assign w_rt_busy = issue_rt_en && (issue_rt != 5'd0) &&
                       (r_cnt[issue_rt] > (issue_read_d ? LAT_W'(0) : LAT_W'(1)));
    // A younger write must not finish before an older write to the same reg.
    assign w_waw     = issue_wr_en && (issue_wr != 5'd0) &&
                       (r_cnt[issue_wr] > issue_lat);
    assign w_dstall  = issue_valid && (w_rs_busy || w_rt_busy || w_waw);

    assign w_accept  = w_advance && !w_exc && issue_valid && !w_dstall &&
                       issue_wr_en && (issue_wr != 5'd0);

    // Next-state for each scoreboard counter; $0 is pinned at zero.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_cnt
            if (gi == 0) begin : g_zero
                assign w_cnt_next[gi] = '0;
            end else begin : g_reg
                logic w_load;
                assign w_load = w_accept && (issue_wr == 5'(gi));
                assign w_cnt_next[gi] =
                    w_exc               ? '0 :
                    !w_advance          ? r_cnt[gi] :
                    w_load              ? issue_lat :
                    (r_cnt[gi] != '0)   ? r_cnt[gi] - LAT_W'(1) :
                                          '0;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                r_cnt[r] <= '0;
            end
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    // Redirect FSM: RUN takes the exception, REDIR presents the target until
    // fetch is able to accept it.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= ST_RUN;
            r_redirect_pc <= EXC_VEC;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_exc) begin
                        r_state       <= ST_REDIR;
                        r_redirect_pc <= (except_type == ERET_CODE) ? cp0_epc : EXC_VEC;
                    end
                end
                ST_REDIR: begin
                    if (!(i_stall || d_stall)) begin
                        r_state <= ST_RUN;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign stallE = w_freeze;
    assign stallM = w_freeze;
    assign stallW = w_freeze;
    assign stallD = w_freeze | w_dstall;
    // In REDIR the PC register must be free to load the redirect target.
    assign stallF = (w_freeze | w_dstall) & !w_redir;

    assign flushD = w_exc | w_redir;
    assign flushE = w_exc | (w_dstall & !w_freeze);
    assign flushM = w_exc;
    assign flushW = w_exc;

    assign redirect_valid = w_redir;
    assign redirect_pc    = r_redirect_pc;

`ifdef HAZARD_PERF_EN
    logic [31:0] r_perf_freeze;
    logic [31:0] r_perf_dstall;
    logic [31:0] r_perf_exc;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_perf_freeze <= '0;
            r_perf_dstall <= '0;
            r_perf_exc    <= '0;
        end else begin
            if (w_freeze)              r_perf_freeze <= r_perf_freeze + 32'd1;
            if (w_dstall && !w_freeze) r_perf_dstall <= r_perf_dstall + 32'd1;
            if (w_exc)                 r_perf_exc    <= r_perf_exc + 32'd1;
        end
    end

    assign perf_freeze_cnt = r_perf_freeze;
    assign perf_dstall_cnt = r_perf_dstall;
    assign perf_exc_cnt    = r_perf_exc;
`endif

endmodule
